iter_mdu: RTL and testbench
===========================

ITER_MDU -- requirements
Module: iter_mdu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, request to issue op; sampled only when busy=0.
REQ-005 The block SHALL have port op, input, 3 bits, operation code: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 The block SHALL have port inA, input, WIDTH bits, multiplicand, dividend, or MTHI/MTLO data.
REQ-007 The block SHALL have port inB, input, WIDTH bits, multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a multiply or divide iterates.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle pulse when a multiply or divide result lands in hi/lo.
REQ-010 The block SHALL have port hi, output, WIDTH bits: product upper half or remainder.
REQ-011 The block SHALL have port lo, output, WIDTH bits: product lower half or quotient.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, FIX; busy=1 in MUL, DIV and FIX, busy=0 in IDLE.
REQ-013 In IDLE, start=1 with op 000/001 SHALL latch operands and enter MUL; start=1 with op 010/011 SHALL latch operands and enter DIV.
REQ-014 MUL and DIV SHALL each last exactly WIDTH cycles (one bit per cycle: shift-add, restoring divide on magnitudes), then go to FIX for 1 cycle, then return to IDLE.
REQ-015 Busy SHALL be high for exactly WIDTH+1 cycles, starting the cycle after the accepting edge.
REQ-016 The FIX to IDLE edge SHALL apply sign correction and update hi/lo; done SHALL be 1 for exactly the first IDLE cycle after completion.
REQ-017 hi/lo SHALL hold their previous values for the whole busy period; partial results stay internal.
REQ-018 Signed ops SHALL operate on two's-complement magnitudes; MULT SHALL give the exact 2*WIDTH-bit signed product; DIV quotient SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-019 Divide by zero (DIV or DIVU) SHALL give lo=all ones and hi=inA unchanged, with normal WIDTH+1 latency and no error flag.
REQ-020 DIV of MIN_NEG by -1 SHALL give lo=MIN_NEG and hi=0.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write inA to hi/lo at that edge, keep busy=0, and not pulse done.
REQ-022 start=1 while busy=1 SHALL be ignored for every op; no queuing, and operands are not re-latched.
REQ-023 Reserved ops SHALL be no-ops: no state change, no done, and hi/lo unchanged.
REQ-024 A new start SHALL be accepted in the same cycle done=1; back-to-back ops need no idle gap.
REQ-025 inA/inB SHALL be don't-care after the accepting edge.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0 and clear internal operand/partial registers, independent of clk.
REQ-027 Reset during MUL/DIV/FIX SHALL abort the operation; no done SHALL follow deassertion, and hi/lo SHALL stay 0.
REQ-028 After reset deassertion, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 WIDTH=32 MULT inA=FFFFFFFD inB=00000005 -> busy high for 33 cycles, then done pulse, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-030 WIDTH=32 DIV inA=FFFFFFF9 inB=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU inA=7 inB=0 -> lo=FFFFFFFF, hi=00000007.
REQ-031 WIDTH=32 DIV inA=80000000 inB=FFFFFFFF -> lo=80000000, hi=00000000, 33 busy cycles.
REQ-032 WIDTH=8 MULTU inA=FF inB=FF -> busy for 9 cycles, then hi=FE, lo=01; then immediate MTLO inA=5A in the done cycle -> lo=5A next cycle, hi=FE.
REQ-033 MTHI start issued mid-multiply -> ignored, hi changes only at completion; reset=0 pulsed mid-multiply -> busy=0, hi=lo=0 asynchronously, and no done afterward.
REQ-034 op=110/111 with start=1 -> busy stays 0, done stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Each MUL/DIV retires one bit per cycle, then a FIX cycle applies the sign correction.
module iter_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   mb;
    logic               neg_lo;
    logic               neg_hi;
    logic               dz;
    logic               is_div;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               last_step;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign last_step = (cnt == CW'(WIDTH - 1));

    always_comb begin
        a_neg = op[0] & inA[WIDTH-1];
        b_neg = op[0] & inB[WIDTH-1];
        a_mag = a_neg ? -inA : inA;
        b_mag = b_neg ? -inB : inB;
    end

    // p holds {partial_hi, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? mb : {WIDTH{1'b0}})};
        div_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_diff = div_sh - {1'b0, mb};
        div_ge   = (div_sh >= {1'b0, mb});
    end

    always_comb begin
        prod_fix = neg_lo ? -p : p;
        q_fix    = dz ? {WIDTH{1'b1}} : (neg_lo ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
        r_fix    = neg_hi ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            p      <= '0;
            mb     <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz     <= 1'b0;
            is_div <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULTU, OP_MULT: begin
                                p      <= {{WIDTH{1'b0}}, b_mag};
                                mb     <= a_mag;
                                neg_lo <= a_neg ^ b_neg;
                                neg_hi <= 1'b0;
                                dz     <= 1'b0;
                                is_div <= 1'b0;
                                cnt    <= '0;
                                state  <= ST_MUL;
                            end
                            OP_DIVU, OP_DIV: begin
                                p      <= {{WIDTH{1'b0}}, a_mag};
                                mb     <= b_mag;
                                neg_lo <= a_neg ^ b_neg;
                                neg_hi <= a_neg;
                                dz     <= (inB == '0);
                                is_div <= 1'b1;
                                cnt    <= '0;
                                state  <= ST_DIV;
                            end
                            OP_MTHI: hi <= inA;
                            OP_MTLO: lo <= inA;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    p   <= {mul_sum, p[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last_step) state <= ST_FIX;
                end
                ST_DIV: begin
                    // Restoring step; a zero divisor naturally yields all-ones quotient.
                    if (div_ge) p <= {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
                    else        p <= {div_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (last_step) state <= ST_FIX;
                end
                default: begin
                    if (is_div) begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mdu.sv
// Directed plus randomized checks of iter_mdu at WIDTH=32 and WIDTH=8 against
// an arithmetic reference model of HI/LO.
module tb_iter_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] a_in = 32'b0;
    logic [31:0] b_in = 32'b0;
    logic        start32 = 1'b0;
    logic        start8 = 1'b0;

    logic        busy32, done32;
    logic [31:0] hi32, lo32;
    logic [1:0]  st32;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;
    logic [1:0]  st8;

    int total = 0;
    int bad = 0;
    logic [63:0] mhi[2];
    logic [63:0] mlo[2];

    always #5 clk = ~clk;

    iter_mdu #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(start32), .op(op), .inA(a_in), .inB(b_in),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .dbg_state(st32)
    );

    iter_mdu #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .op(op), .inA(a_in[7:0]), .inB(b_in[7:0]),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbg_state(st8)
    );

    function automatic logic [63:0] g_hi(int w);
        return (w == 32) ? {32'd0, hi32} : {56'd0, hi8};
    endfunction
    function automatic logic [63:0] g_lo(int w);
        return (w == 32) ? {32'd0, lo32} : {56'd0, lo8};
    endfunction
    function automatic logic g_busy(int w);
        return (w == 32) ? busy32 : busy8;
    endfunction
    function automatic logic g_done(int w);
        return (w == 32) ? done32 : done8;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 32) start32 = v;
        else start8 = v;
    endtask

    // Reference: plain integer arithmetic on sign-extended operands.
    task automatic model(input int w, input logic [2:0] o, input logic [63:0] a_raw,
                         input logic [63:0] b_raw, output logic [63:0] eh, output logic [63:0] el);
        logic [63:0] mask, a, b, prod;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a = a_raw & mask;
        b = b_raw & mask;
        sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
        sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
        prod = 64'd0;
        eh = 64'd0;
        el = 64'd0;
        case (o)
            3'd0, 3'd1: begin
                if (o == 3'd0) prod = a * b;
                else prod = sa * sb;
                el = prod & mask;
                eh = (prod >> w) & mask;
            end
            default: begin
                if (b == 64'd0) begin
                    el = mask;
                    eh = a;
                end else if (o == 3'd2) begin
                    el = a / b;
                    eh = a % b;
                end else begin
                    el = sa / sb;
                    eh = sa % sb;
                end
                el &= mask;
                eh &= mask;
            end
        endcase
    endtask

    // Caller is at a negedge; the op is accepted at the next posedge.
    task automatic do_op(input int w, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        int idx, n;
        logic held;
        logic [63:0] eh, el;
        idx = (w == 32) ? 0 : 1;
        model(w, o, {32'd0, a}, {32'd0, b}, eh, el);
        op = o;
        a_in = a;
        b_in = b;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        a_in = $urandom;
        b_in = $urandom;
        op = 3'($urandom_range(0, 7));
        chk({tag, "_done_low"}, {63'd0, g_done(w)}, 64'd0);
        n = 0;
        held = 1'b1;
        while (g_busy(w) === 1'b1 && n < 200) begin
            if (g_hi(w) !== mhi[idx] || g_lo(w) !== mlo[idx]) held = 1'b0;
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(w + 1));
        chk({tag, "_hold"}, {63'd0, held}, 64'd1);
        chk({tag, "_done"}, {63'd0, g_done(w)}, 64'd1);
        chk({tag, "_hi"}, g_hi(w), eh);
        chk({tag, "_lo"}, g_lo(w), el);
        mhi[idx] = eh;
        mlo[idx] = el;
    endtask

    task automatic do_mt(input int w, input logic [2:0] o, input logic [31:0] a, input string tag);
        int idx;
        logic [63:0] mask;
        idx = (w == 32) ? 0 : 1;
        mask = (64'd1 << w) - 64'd1;
        op = o;
        a_in = a;
        b_in = $urandom;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        if (o == 3'd4) mhi[idx] = {32'd0, a} & mask;
        if (o == 3'd5) mlo[idx] = {32'd0, a} & mask;
        chk({tag, "_busy"}, {63'd0, g_busy(w)}, 64'd0);
        chk({tag, "_done"}, {63'd0, g_done(w)}, 64'd0);
        chk({tag, "_hi"}, g_hi(w), mhi[idx]);
        chk({tag, "_lo"}, g_lo(w), mlo[idx]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] eh, el;
        int n, dn;
        int w;
        logic [31:0] ra, rb;
        mhi[0] = 64'd0; mlo[0] = 64'd0;
        mhi[1] = 64'd0; mlo[1] = 64'd0;

        #1;
        chk("rst_busy32", {63'd0, busy32}, 64'd0);
        chk("rst_done32", {63'd0, done32}, 64'd0);
        chk("rst_hi32", {32'd0, hi32}, 64'd0);
        chk("rst_lo32", {32'd0, lo32}, 64'd0);
        chk("rst_busy8", {63'd0, busy8}, 64'd0);
        chk("rst_lo8", {56'd0, lo8}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_op(32, 3'd1, 32'hFFFFFFFD, 32'h00000005, "mult_neg");
        do_op(32, 3'd3, 32'hFFFFFFF9, 32'h00000002, "div_neg");
        do_op(32, 3'd2, 32'h00000007, 32'h00000000, "divu_zero");
        do_op(32, 3'd3, 32'h80000000, 32'hFFFFFFFF, "div_min");
        do_op(32, 3'd3, 32'hFFFFFFF9, 32'h00000000, "div_zero_neg");
        do_op(32, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        do_op(8, 3'd0, 32'h000000FF, 32'h000000FF, "multu8");
        do_mt(8, 3'd5, 32'h0000005A, "mtlo8_b2b");
        do_op(8, 3'd3, 32'h00000080, 32'h000000FF, "div8_min");

        do_mt(32, 3'd6, 32'h12345678, "rsv6");
        do_mt(32, 3'd7, 32'h87654321, "rsv7");
        do_mt(32, 3'd4, 32'hCAFEF00D, "mthi");
        do_mt(32, 3'd5, 32'h0BADBEEF, "mtlo");

        // Starts issued mid-multiply must be ignored.
        model(32, 3'd1, 64'h12345678, 64'hF0F0F0F0, eh, el);
        op = 3'd1; a_in = 32'h12345678; b_in = 32'hF0F0F0F0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'd4; a_in = 32'hDEADBEEF; start32 = 1'b1;
        @(negedge clk);
        chk("mid_mthi_hi", {32'd0, hi32}, mhi[0]);
        op = 3'd0; a_in = 32'd1; b_in = 32'd1;
        @(negedge clk);
        start32 = 1'b0;
        chk("mid_busy", {63'd0, busy32}, 64'd1);
        n = 0;
        while (busy32 === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("mid_done", {63'd0, done32}, 64'd1);
        chk("mid_hi", {32'd0, hi32}, eh);
        chk("mid_lo", {32'd0, lo32}, el);
        mhi[0] = eh; mlo[0] = el;

        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 1) == 0) ? 32 : 8;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) < 8)
                do_op(w, 3'($urandom_range(0, 3)), ra, rb, "rand_op");
            else
                do_mt(w, 3'($urandom_range(4, 7)), ra, "rand_mt");
        end

        // Asynchronous reset mid-multiply aborts with no done afterward.
        op = 3'd1; a_in = 32'h00000123; b_in = 32'h00000456; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy32}, 64'd0);
        chk("arst_hi", {32'd0, hi32}, 64'd0);
        chk("arst_lo", {32'd0, lo32}, 64'd0);
        chk("arst_hi8", {56'd0, hi8}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        mhi[0] = 64'd0; mlo[0] = 64'd0;
        mhi[1] = 64'd0; mlo[1] = 64'd0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 === 1'b1 || busy32 === 1'b1) dn++;
        end
        chk("arst_no_done", 64'(dn), 64'd0);
        chk("arst_hold_hi", {32'd0, hi32}, 64'd0);
        chk("arst_hold_lo", {32'd0, lo32}, 64'd0);

        do_op(32, 3'd1, 32'hFFFFFFFD, 32'h00000005, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
